// File: rtl/serial_gen_pkg.sv
// Shared types and constants for the serial pattern generator.
// The state encoding is also exposed on the top level for checkers.
package serial_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int   DEFAULT_WIDTH      = 16;
    localparam int   LEN_W              = clog2(DEFAULT_WIDTH + 1);
    localparam logic DEFAULT_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/bit_period_counter.sv
// Hold-period counter: pulses tick on the last clock of every bit period.
// With a one-clock period the tick is simply the enable.
module bit_period_counter
    import serial_gen_pkg::*;
#(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    generate
        if (BIT_CYCLES <= 1) begin : g_const
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst, clr};
            assign tick      = en;
        end else begin : g_cnt
            localparam int CW = clog2(BIT_CYCLES);
            localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

            logic [CW-1:0] cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                end else if (clr) begin
                    cnt <= '0;
                end else if (en) begin
                    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                end
            end

            assign tick = en && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/serial_pattern_gen.sv
// Loads a parallel pattern and shifts it out MSB-first on j, each bit held
// BIT_CYCLES clocks, finishing with a one-cycle done pulse.
module serial_pattern_gen
    import serial_gen_pkg::*;
#(
    parameter int   WIDTH      = DEFAULT_WIDTH,
    parameter int   BIT_CYCLES = 1,
    parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL,
    localparam int  LW         = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LW-1:0]    load_len,
    output logic             j,
    output logic             j_valid,
    output logic             busy,
    output logic             done,
    output state_t           fsm_state
);

    // Load handshake: a transfer happens on a rising edge where load_valid
    // and load_ready are both high. load_ready is high only in IDLE and out
    // of reset; requests in any other cycle are dropped, not queued.

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [LW-1:0]    bit_cnt;
    logic [LW-1:0]    len;
    logic [WIDTH-1:0] aligned;
    logic [WIDTH-1:0] next_sreg;
    logic             accept;
    logic             shifting;
    logic             tick;

    assign load_ready = (state == IDLE) && !rst;
    assign accept     = load_valid && load_ready;
    assign shifting   = (state == SHIFT);
    assign busy       = (state != IDLE);
    assign fsm_state  = state;

    // Clamp the length, then left-align so the first bit sits at the MSB.
    always_comb begin
        len       = (int'(load_len) > WIDTH) ? LW'(WIDTH) : load_len;
        aligned   = load_data << (WIDTH - int'(len));
        next_sreg = sreg << 1;
    end

    bit_period_counter #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_period (
        .clk (clk),
        .rst (rst),
        .en  (shifting),
        .clr (accept),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            j       <= IDLE_LEVEL;
            j_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= SHIFT;
                            sreg    <= aligned;
                            bit_cnt <= len - 1'b1;
                            j       <= aligned[WIDTH-1];
                            j_valid <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (bit_cnt == '0) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            sreg    <= '0;
                            j       <= IDLE_LEVEL;
                            j_valid <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                            sreg    <= next_sreg;
                            j       <= next_sreg[WIDTH-1];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    j       <= IDLE_LEVEL;
                    j_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: one instance with 1-clock bits, one with
// 3-clock bits, plus a 10010 detector model watching the first stream.
module tb_serial_pattern_gen;
    import serial_gen_pkg::*;

    localparam int W  = 16;
    localparam int LW = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst_a, rst_b;
    logic          load_valid_a, load_valid_b;
    logic          load_ready_a, load_ready_b;
    logic [W-1:0]  load_data_a, load_data_b;
    logic [LW-1:0] load_len_a, load_len_b;
    logic          j_a, j_b, j_valid_a, j_valid_b;
    logic          busy_a, busy_b, done_a, done_b;
    state_t        fsm_state_a, fsm_state_b;

    serial_pattern_gen #(.WIDTH(W), .BIT_CYCLES(1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst(rst_a), .load_valid(load_valid_a), .load_ready(load_ready_a),
        .load_data(load_data_a), .load_len(load_len_a), .j(j_a), .j_valid(j_valid_a),
        .busy(busy_a), .done(done_a), .fsm_state(fsm_state_a)
    );

    serial_pattern_gen #(.WIDTH(W), .BIT_CYCLES(3), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .load_valid(load_valid_b), .load_ready(load_ready_b),
        .load_data(load_data_b), .load_len(load_len_b), .j(j_b), .j_valid(j_valid_b),
        .busy(busy_b), .done(done_b), .fsm_state(fsm_state_b)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [0:0] exp_q_a[$];
    logic [0:0] exp_q_b[$];
    int start_q_a[$], done_q_a[$], det_q_a[$];
    int start_q_b[$], done_q_b[$];
    int done_cnt_a = 0, det_cnt_a = 0;
    bit in_stream_a = 1'b0, in_stream_b = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event seen with no pending expectation (cycle %0d)", name, cyc);
    endtask

    // 10010 Mealy detector model; history is cleared whenever j is not valid.
    logic [3:0] hist_a;
    logic       det_a;
    assign det_a = !rst_a && j_valid_a && (hist_a == 4'b1001) && (j_a == 1'b0);
    always @(posedge clk or posedge rst_a) begin
        if (rst_a)           hist_a <= 4'b0;
        else if (!j_valid_a) hist_a <= 4'b0;
        else                 hist_a <= {hist_a[2:0], j_a};
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst_a) begin
            if (j_valid_a) begin
                chk("busy_shift_a", busy_a, 1);
                if (!in_stream_a) begin
                    in_stream_a = 1'b1;
                    if (start_q_a.size() == 0) flag_fail("start_a");
                    else chk("start_cycle_a", cyc, start_q_a.pop_front());
                end
                if (exp_q_a.size() == 0) flag_fail("bit_a");
                else chk("bit_a", j_a, exp_q_a.pop_front());
            end else begin
                in_stream_a = 1'b0;
                chk("idle_level_a", j_a, 0);
            end
            if (done_a) begin
                done_cnt_a++;
                chk("done_busy_a", busy_a, 1);
                chk("done_bits_left_a", exp_q_a.size(), 0);
                if (done_q_a.size() == 0) flag_fail("done_a");
                else chk("done_cycle_a", cyc, done_q_a.pop_front());
            end
            if (det_a) begin
                det_cnt_a++;
                if (det_q_a.size() == 0) flag_fail("detect_a");
                else chk("detect_cycle_a", cyc, det_q_a.pop_front());
            end
        end else begin
            in_stream_a = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst_b) begin
            if (j_valid_b) begin
                if (!in_stream_b) begin
                    in_stream_b = 1'b1;
                    if (start_q_b.size() == 0) flag_fail("start_b");
                    else chk("start_cycle_b", cyc, start_q_b.pop_front());
                end
                if (exp_q_b.size() == 0) flag_fail("bit_b");
                else chk("bit_b", j_b, exp_q_b.pop_front());
            end else begin
                in_stream_b = 1'b0;
                chk("idle_level_b", j_b, 0);
            end
            if (done_b) begin
                chk("done_bits_left_b", exp_q_b.size(), 0);
                if (done_q_b.size() == 0) flag_fail("done_b");
                else chk("done_cycle_b", cyc, done_q_b.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // stream holds the hand-computed j value for each of the n valid cycles,
    // first cycle in bit n-1. det_off < 0 means no detection expected.
    task automatic do_load(input int inst, input logic [W-1:0] data, input logic [LW-1:0] len,
                           input logic [31:0] stream, input int n, input int det_off,
                           input bit scramble, output int acc);
        int waited;
        waited = 0;
        acc    = -1;
        @(negedge clk);
        if (inst == 0) begin load_valid_a = 1'b1; load_data_a = data; load_len_a = len; end
        else           begin load_valid_b = 1'b1; load_data_b = data; load_len_b = len; end
        while (!((inst == 0) ? load_ready_a : load_ready_b) && waited < 300) begin
            if (scramble) begin
                if (inst == 0) load_data_a = W'($urandom_range(0, 65535));
                else           load_data_b = W'($urandom_range(0, 65535));
            end
            @(negedge clk);
            waited++;
        end
        if (waited >= 300) begin
            flag_fail("load_timeout");
        end else begin
            if (inst == 0) load_data_a = data;
            else           load_data_b = data;
            acc = cyc + 1;
            for (int i = n - 1; i >= 0; i--) begin
                if (inst == 0) exp_q_a.push_back(stream[i]);
                else           exp_q_b.push_back(stream[i]);
            end
            if (inst == 0) begin
                if (n > 0) start_q_a.push_back(acc);
                done_q_a.push_back(acc + n);
                if (det_off >= 0) det_q_a.push_back(acc + det_off);
            end else begin
                if (n > 0) start_q_b.push_back(acc);
                done_q_b.push_back(acc + n);
            end
        end
        @(posedge clk);
        #1;
        if (inst == 0) load_valid_a = 1'b0;
        else           load_valid_b = 1'b0;
    endtask

    task automatic wait_drain(input int inst);
        int t;
        t = 0;
        while (((inst == 0) ? done_q_a.size() : done_q_b.size()) != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) flag_fail("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int acc1, acc2, d0, k0;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        load_valid_a = 1'b0; load_valid_b = 1'b0;
        load_data_a = '0; load_data_b = '0;
        load_len_a = '0; load_len_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_j", j_a, 0);
        chk("rst_j_valid", j_valid_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_load_ready", load_ready_a, 0);
        chk("rst_state", fsm_state_a, IDLE);
        chk("rst_load_ready_b", load_ready_b, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        chk("ready_after_rst", load_ready_a, 1);

        // Basic 10010 stream: detector fires on the fifth bit.
        do_load(0, 16'h0012, 5'd5, 32'b10010, 5, 4, 1'b0, acc1);
        wait_drain(0);

        // Bit stretching, 3 clocks per bit.
        do_load(1, 16'h0005, 5'd3, 32'b111000111, 9, -1, 1'b0, acc1);
        wait_drain(1);

        // Zero length: done on the cycle right after accept, no bits.
        do_load(0, 16'hFFFF, 5'd0, 32'h0, 0, -1, 1'b0, acc1);
        wait_drain(0);

        // Overlong length clamps to 16 bits, starting from bit 15.
        do_load(0, 16'hF0F0, 5'd20, 32'h0000F0F0, 16, -1, 1'b0, acc1);
        wait_drain(0);

        // Busy handshake: second request held with garbage data during SHIFT.
        do_load(0, 16'h00B3, 5'd8, 32'hB3, 8, -1, 1'b0, acc1);
        do_load(0, 16'h0012, 5'd5, 32'b10010, 5, 4, 1'b1, acc2);
        chk("busy_accept_cycle", acc2, acc1 + 10);
        wait_drain(0);

        // Asynchronous reset in the middle of an 8-bit pattern.
        d0 = done_cnt_a;
        do_load(0, 16'h00C5, 5'd8, 32'hC5, 8, -1, 1'b0, acc1);
        repeat (3) @(posedge clk);
        #2;
        rst_a = 1'b1;
        #1;
        chk("midrst_j", j_a, 0);
        chk("midrst_j_valid", j_valid_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_bits_left", exp_q_a.size(), 5);
        exp_q_a.delete();
        start_q_a.delete();
        done_q_a.delete();
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        #1;
        chk("midrst_ready", load_ready_a, 1);
        chk("midrst_state", fsm_state_a, IDLE);
        repeat (3) @(negedge clk);
        chk("midrst_no_done", done_cnt_a, d0);
        do_load(0, 16'h0012, 5'd5, 32'b10010, 5, 4, 1'b0, acc1);
        wait_drain(0);

        // Back-to-back 10010 loads: 2-cycle idle gap, two done pulses.
        d0 = done_cnt_a;
        k0 = det_cnt_a;
        do_load(0, 16'h0012, 5'd5, 32'b10010, 5, 4, 1'b0, acc1);
        do_load(0, 16'h0012, 5'd5, 32'b10010, 5, 4, 1'b0, acc2);
        chk("b2b_accept_cycle", acc2, acc1 + 7);
        wait_drain(0);
        chk("b2b_done_count", done_cnt_a - d0, 2);
        chk("b2b_detect_count", det_cnt_a - k0, 2);

        chk("end_bits_a", exp_q_a.size(), 0);
        chk("end_det_a", det_q_a.size(), 0);
        chk("end_bits_b", exp_q_b.size(), 0);
        chk("end_done_b", done_q_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
